// File: rtl/y_sram_read_arbiter.sv
// Round-robin arbiter for the shared y_sram read port: one grant per cycle, ID-tagged responses.
// Optional ARB_BURST_EN: a granted requester keeps the port for up to MAX_BURST consecutive reads.
module y_sram_read_arbiter #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int AW        = 11,
  parameter int DW        = 256,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  output logic [NREQ-1:0]      gnt,
  output logic [AW-1:0]        sram_addr,
  output logic                 sram_rd_en,
  input  logic [DW-1:0]        sram_rdata,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_data,
  output logic                 busy
);

  logic [IDW-1:0]            ptr;
  logic [IDW-1:0]            idx;
  logic [IDW-1:0]            gid;
  logic [IDW-1:0]            nxt;
  logic                      found;
  logic [AW-1:0]             addr_sel;
  logic [RD_LAT:0]           vld_pipe;
  logic [RD_LAT:0][IDW-1:0]  id_pipe;

  // Search ptr, ptr+1, ... (mod NREQ) for the first active request.
  always_comb begin
    found = 1'b0;
    gid   = ptr;
    idx   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        gid   = idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found && reset) gnt[gid] = 1'b1;
  end

  // Constant-index mux so unselected (possibly X) addresses never reach the register.
  always_comb begin
    addr_sel = '0;
    for (int k = 0; k < NREQ; k++)
      if (gid == IDW'(k)) addr_sel = req_addr[k*AW +: AW];
  end

  assign nxt = (int'(gid) == NREQ-1) ? '0 : gid + 1'b1;

`ifdef ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST+1);
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] new_cnt;
  logic [IDW-1:0] ptr_inc;

  assign new_cnt = (gid == ptr) ? burst_cnt + 1'b1 : CW'(1);
  assign ptr_inc = (int'(ptr) == NREQ-1) ? '0 : ptr + 1'b1;

  // ptr parks on the burst owner; it moves on when the burst is exhausted or the owner goes idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      burst_cnt <= '0;
    end else if (found) begin
      if (int'(new_cnt) >= MAX_BURST) begin
        ptr       <= nxt;
        burst_cnt <= '0;
      end else begin
        ptr       <= gid;
        burst_cnt <= new_cnt;
      end
    end else if (burst_cnt != '0 && !req[ptr]) begin
      ptr       <= ptr_inc;
      burst_cnt <= '0;
    end
  end
`else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     ptr <= '0;
    else if (found) ptr <= nxt;
  end
`endif

  // Stage 0 is the registered SRAM command; stage RD_LAT lines up with ReadBus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sram_addr <= '0;
      vld_pipe  <= '0;
      id_pipe   <= '0;
    end else begin
      if (found) sram_addr <= addr_sel;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], found};
      id_pipe  <= {id_pipe[RD_LAT-1:0], gid};
    end
  end

  assign sram_rd_en = vld_pipe[0];
  assign rsp_valid  = vld_pipe[RD_LAT];
  assign rsp_id     = id_pipe[RD_LAT];
  assign rsp_data   = sram_rdata;
  assign busy       = |vld_pipe;

endmodule

// File: tb/tb_y_sram_read_arbiter.sv
// Scoreboard bench for y_sram_read_arbiter: reference rotation model feeds an expected-response queue.
module tb_y_sram_read_arbiter;
  localparam int NREQ = 4, IDW = 2, AW = 11, DW = 256, RD_LAT = 1;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]    gnt;
  logic [AW-1:0]      sram_addr;
  logic               sram_rd_en;
  logic [DW-1:0]      sram_rdata = '0;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               busy;

  y_sram_read_arbiter #(.NREQ(NREQ), .IDW(IDW), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(4)) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt),
    .sram_addr(sram_addr), .sram_rd_en(sram_rd_en), .sram_rdata(sram_rdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    int             due;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            passed = 0;
  int            cyc = 0;
  int            ptr_m = 0;
  bit            g_d1 = 0, g_d2 = 0;
  logic [AW-1:0] exp_addr = '0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++)
      d[i*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(i) << 24) ^ 32'h5A5A0000;
    return d;
  endfunction

  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) if (sram_rd_en) sram_rdata <= memf(sram_addr);

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // One clock: apply req/addresses, check registered outputs from earlier grants, then the new grant.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*AW-1:0] a, output int g);
    g = -1;
    @(posedge clock); #1;
    req = r; req_addr = a;
    #1;
    chk("sram_rd_en", sram_rd_en, g_d1);
    if (g_d1) chk("sram_addr", sram_addr, exp_addr);
    chk("busy", busy, g_d1 | g_d2);
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && r[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
    chk("gnt", gnt, (g < 0) ? 0 : (1 << g));
    g_d2 = g_d1;
    g_d1 = (g >= 0);
    if (g >= 0) begin
      exp_addr = a[g*AW +: AW];
      q.push_back('{IDW'(g), memf(exp_addr), cyc + 1 + RD_LAT});
      ptr_m = (g + 1) % NREQ;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b0; req = '1; req_addr = 'x;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_sram_rd_en", sram_rd_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    q.delete();
    ptr_m = 0; g_d1 = 0; g_d2 = 0; exp_addr = '0;
    repeat (2) @(posedge clock);
    #1 chk("rst_gnt_hold", gnt, 0);
    @(negedge clock);
    req = '0; req_addr = '0;
    reset = 1'b1;
  endtask

  function automatic logic [NREQ*AW-1:0] rand_addrs(input logic [NREQ-1:0] m);
    logic [NREQ*AW-1:0] a;
    a = 'x;
    for (int i = 0; i < NREQ; i++) if (m[i]) a[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
    return a;
  endfunction

  // Monitor: every presented response must match the oldest expected one, on its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (rsp_valid) begin
          if (q.size() == 0) begin
            checks++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 id=%0d, expected no response (cycle %0d)", rsp_id, cyc);
          end else begin
            e = q.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_cycle", cyc, e.due);
          end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
          checks++;
          $display("FAIL rsp_missing: got no rsp_valid, expected id=%0d at cycle %0d", q[0].id, q[0].due);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int g;
    logic [NREQ*AW-1:0] a;
    logic [NREQ-1:0]    pend;
    logic [NREQ*AW-1:0] pa;

    do_reset();

    // Single request from requester 2, other addresses X
    a = 'x;
    a[2*AW +: AW] = 11'h05A;
    step(4'b0100, a, g);
    chk("single_gid", g, 2);
    repeat (3) step('0, 'x, g);

    // Fairness from reset with all requesting
    do_reset();
    for (int n = 0; n < 8; n++) begin
      step(4'hF, rand_addrs(4'hF), g);
      chk("fair_order", g, n % NREQ);
    end
    repeat (3) step('0, 'x, g);

    // Wrap past idle requesters back to 0
    step(4'b0001, rand_addrs(4'b0001), g);
    step(4'b0001, rand_addrs(4'b0001), g);
    chk("wrap_gid", g, 0);
    repeat (3) step('0, 'x, g);

    // Reset while a read is in flight
    do_reset();
    step(4'b0100, rand_addrs(4'b0100), g);
    do_reset();
    repeat (4) step('0, 'x, g);
    step(4'hF, rand_addrs(4'hF), g);
    chk("post_reset_gid", g, 0);
    repeat (3) step('0, 'x, g);

    // Random traffic: each requester holds its request and address until granted
    pend = '0;
    pa = 'x;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          pa[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
        end
      a = 'x;
      for (int i = 0; i < NREQ; i++) if (pend[i]) a[i*AW +: AW] = pa[i*AW +: AW];
      step(pend, a, g);
      if (g >= 0) begin
        pend[g] = 1'b0;
        pa[g*AW +: AW] = 'x;
      end
    end
    repeat (4) step('0, 'x, g);
    chk("drain_queue", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
